regfile_ctx_engine: RTL and testbench
=====================================

Name: regfile_ctx_engine

Overview:
Context save/restore sequencer that drives a register file's write port and one combinational read port.
- Save: streams registers lo..hi out of the register file on a valid/ready source interface toward memory or a debug bus.
- Restore: accepts a valid/ready sink stream and writes it back into registers lo..hi.
- Sits beside the core's register file, muxed onto its ports by the core while the core is stalled (used for interrupts and debug).

Parameters:
WIDTH, 32, register data width
RSELWIDTH, 4, register select width; register count is 2**RSELWIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin operation; sampled only in IDLE
mode  in  1  0 = save, 1 = restore; latched with start
lo  in  RSELWIDTH  first register; latched with start
hi  in  RSELWIDTH  last register, inclusive; latched with start
abort  in  1  cancel operation in progress
busy  out  1  high in SAVE or RESTORE
done  out  1  one-cycle pulse on normal completion
rf_asel  out  RSELWIDTH  register file read select
rf_adata  in  WIDTH  register file read data, combinational from rf_asel
rf_we  out  1  register file write enable
rf_wsel  out  RSELWIDTH  register file write select
rf_wdata  out  WIDTH  register file write data
out_valid  out  1  save stream valid
out_ready  in  1  save stream ready
out_data  out  WIDTH  save stream data
out_idx  out  RSELWIDTH  register number of out_data
in_valid  in  1  restore stream valid
in_ready  out  1  restore stream ready
in_data  in  WIDTH  restore stream data

Behaviour:
- Clocking/reset: single clock clk; synchronous active-high reset rst.
- Reset values: state = IDLE, idx = 0, busy = 0, done = 0, out_valid = 0, out_data = 0, out_idx = 0, rf_we = 0.
- Reset mid-operation: aborts immediately; no rf_we in the reset cycle or after it.
- States: IDLE, SAVE, RESTORE, DONE.

IDLE:
- start = 1 latches mode, lo, hi; sets idx = lo.
- Next state is SAVE (mode 0) or RESTORE (mode 1).
- If lo > hi: range is empty; go directly to DONE with zero transfers.

SAVE:
- rf_asel = idx combinationally; rf_asel = 0 outside SAVE.
- Output is a single registered stage. Load when (!out_valid || out_ready) and not all_issued:
  - out_data <= rf_adata, out_idx <= idx, out_valid <= 1.
  - If idx == hi, set all_issued; else idx <= idx + 1.
- Handshake with nothing left to load: out_ready with out_valid clears out_valid.
- Throughput: 1 word/cycle while out_ready = 1. First out_valid appears the cycle after SAVE is entered.
- out_data and out_idx are stable while out_valid && !out_ready.
- Transition to DONE in the cycle the final word handshakes (all_issued and out_valid and out_ready).

RESTORE:
- in_ready = 1 only in RESTORE.
- rf_we = in_valid & in_ready (combinational, same-cycle write).
- rf_wsel = idx, rf_wdata = in_data. rf_wsel and rf_wdata are don't-care when rf_we = 0.
- On each write: if idx == hi go to DONE, else idx <= idx + 1.
- Words arriving outside RESTORE are not accepted (in_ready = 0).

DONE:
- done = 1 for exactly one cycle; busy = 0.
- Next state IDLE. start in the DONE cycle is ignored.

abort:
- In SAVE or RESTORE: next state IDLE, out_valid cleared, no done pulse.
- In the abort cycle, a RESTORE beat with in_valid still writes; abort has priority over DONE.
- Ignored in IDLE and DONE.

Arithmetic and boundaries:
- Compare idx == hi before incrementing, so hi = 2**RSELWIDTH-1 never wraps.
- lo == hi transfers exactly one register.
- start while busy is ignored.
- Register file is never written during SAVE and never read-selected during RESTORE.

Test Plan:
1. Save, full range: preload R[i] = 0x100+i, lo = 0, hi = 15, out_ready = 1 -> 16 beats on consecutive cycles, out_idx 0..15, out_data 0x100..0x10F, done one cycle after the last beat, busy low with done.
2. Save backpressure: lo = 3, hi = 5, out_ready toggling 1,0,0,1,... -> exactly 3 beats (0x103, 0x104, 0x105); out_data/out_idx held during stalls; no duplicate or skipped index.
3. Restore: lo = 14, hi = 15, in_data 0xDEAD0001 then 0xDEAD0002 with a one-cycle in_valid gap -> rf_we in exactly 2 cycles, R[14] = 0xDEAD0001, R[15] = 0xDEAD0002, done after the second write, no idx wrap.
4. Empty and single range: lo = 7, hi = 6 -> done on the 2nd cycle after start, no out_valid or rf_we. lo = hi = 9, save -> one beat, out_idx = 9.
5. Abort/reset mid-op: restore lo = 0, hi = 15, abort after 4 writes -> R[0..3] written, R[4..] unchanged, no done, in_ready = 0 next cycle. Repeat with rst instead -> all outputs at reset values next cycle.
6. start while busy, and start in the DONE cycle -> both ignored, latched range unchanged.

Source files
------------

// File: rtl/regfile_ctx_engine.sv
// Context save/restore sequencer for a register file: streams registers lo..hi
// out on a valid/ready source (save) or writes a valid/ready sink into them (restore).
module regfile_ctx_engine #(
    parameter int WIDTH     = 32,
    parameter int RSELWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [RSELWIDTH-1:0] lo,
    input  logic [RSELWIDTH-1:0] hi,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [RSELWIDTH-1:0] rf_asel,
    input  logic [WIDTH-1:0]     rf_adata,
    output logic                 rf_we,
    output logic [RSELWIDTH-1:0] rf_wsel,
    output logic [WIDTH-1:0]     rf_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [RSELWIDTH-1:0] out_idx,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [RSELWIDTH-1:0] IDX_ZERO = {RSELWIDTH{1'b0}};
    localparam logic [RSELWIDTH-1:0] IDX_ONE  = {{(RSELWIDTH-1){1'b0}}, 1'b1};

    state_t               state_r;
    logic [RSELWIDTH-1:0] idx_r;
    logic [RSELWIDTH-1:0] hi_r;
    logic                 all_issued_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 out_valid_r;
    logic [WIDTH-1:0]     out_data_r;
    logic [RSELWIDTH-1:0] out_idx_r;

    logic                 load_s;
    logic                 last_beat_s;
    logic                 in_ready_s;
    logic                 wr_s;
    logic [RSELWIDTH-1:0] rf_asel_s;

    // Per-cycle strobes for the save output stage and the restore write port
    always_comb begin
        load_s      = 1'b0;
        last_beat_s = 1'b0;
        in_ready_s  = 1'b0;
        wr_s        = 1'b0;
        rf_asel_s   = IDX_ZERO;
        if (state_r == ST_SAVE) begin
            rf_asel_s   = idx_r;
            load_s      = (!out_valid_r || out_ready) && !all_issued_r;
            last_beat_s = all_issued_r && out_valid_r && out_ready;
        end else if (state_r == ST_RESTORE) begin
            // Gated by rst so no write can land in a reset cycle
            in_ready_s = !rst;
            wr_s       = in_valid && !rst;
        end else begin
            rf_asel_s = IDX_ZERO;
        end
    end

    // Sequencer state, register index and the single-entry save output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            hi_r         <= IDX_ZERO;
            all_issued_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_idx_r    <= IDX_ZERO;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        hi_r         <= hi;
                        idx_r        <= lo;
                        all_issued_r <= 1'b0;
                        if (lo > hi) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (mode) begin
                            state_r <= ST_RESTORE;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_SAVE;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_SAVE: begin
                    if (abort) begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        out_valid_r  <= 1'b0;
                        all_issued_r <= 1'b0;
                    end else begin
                        if (load_s) begin
                            out_data_r  <= rf_adata;
                            out_idx_r   <= idx_r;
                            out_valid_r <= 1'b1;
                            // Compare before incrementing so hi at the top never wraps
                            if (idx_r == hi_r) begin
                                all_issued_r <= 1'b1;
                            end else begin
                                idx_r <= idx_r + IDX_ONE;
                            end
                        end else if (out_valid_r && out_ready) begin
                            out_valid_r <= 1'b0;
                        end
                        if (last_beat_s) begin
                            state_r      <= ST_DONE;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            all_issued_r <= 1'b0;
                        end
                    end
                end
                ST_RESTORE: begin
                    // The beat in an abort cycle is still written (combinational rf_we)
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (wr_s) begin
                        if (idx_r == hi_r) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rf_asel   = rf_asel_s;
    assign rf_we     = wr_s;
    assign rf_wsel   = idx_r;
    assign rf_wdata  = in_data;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign in_ready  = in_ready_s;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Scoreboard bench for regfile_ctx_engine: directed save/restore vectors push
// expected beats, writes and done pulses; a negedge monitor pops and compares.
module tb_regfile_ctx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic        abort;
    logic        busy;
    logic        done;
    logic [3:0]  rf_asel;
    logic [31:0] rf_adata;
    logic        rf_we;
    logic [3:0]  rf_wsel;
    logic [31:0] rf_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_beats[$];
    beat_t       exp_wr[$];
    int          exp_done = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [16];
    logic        load_mem;
    logic        hold_pend = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_idx;
    beat_t       mb;

    always #5 clk = ~clk;

    regfile_ctx_engine #(.WIDTH(32), .RSELWIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .lo(lo), .hi(hi),
        .abort(abort), .busy(busy), .done(done), .rf_asel(rf_asel),
        .rf_adata(rf_adata), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .rf_wdata(rf_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data)
    );

    // Register file the engine is attached to
    assign rf_adata = mem[rf_asel];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
        end else if (rf_we) begin
            mem[rf_wsel] <= rf_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats/writes/done pulses as the DUT presents them
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_beats.size() == 0) begin
                chk("unexpected_beat", {28'd0, out_idx, out_data}, 64'd0);
            end else begin
                mb = exp_beats.pop_front();
                chk("beat_idx", 64'(out_idx), 64'(mb.idx));
                chk("beat_data", 64'(out_data), 64'(mb.data));
            end
        end
        if (rf_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", {28'd0, rf_wsel, rf_wdata}, 64'd0);
            end else begin
                mb = exp_wr.pop_front();
                chk("wr_sel", 64'(rf_wsel), 64'(mb.idx));
                chk("wr_data", 64'(rf_wdata), 64'(mb.data));
            end
        end
        if (done === 1'b1) begin
            if (exp_done == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_done--;
                chk("busy_with_done", 64'(busy), 64'd0);
            end
        end
        if (hold_pend && out_valid === 1'b1) begin
            chk("hold_data", 64'(out_data), 64'(held_data));
            chk("hold_idx", 64'(out_idx), 64'(held_idx));
        end
        hold_pend = (out_valid === 1'b1) && (out_ready === 1'b0);
        held_data = out_data;
        held_idx  = out_idx;
    end

    task automatic start_op(input logic m, input logic [3:0] l, input logic [3:0] h);
        @(posedge clk); #1;
        start = 1'b1; mode = m; lo = l; hi = h;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_beat(ref beat_t q[$], input logic [3:0] i, input logic [31:0] d);
        beat_t b;
        b.idx = i; b.data = d;
        q.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_wr.size() != 0 || exp_done != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_beats.size() + exp_wr.size() + exp_done), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load_mem = 1'b1; start = 1'b0; mode = 1'b0; lo = 4'd0; hi = 4'd0;
        abort = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; load_mem = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);

        // 1: full-range save at full throughput
        for (int i = 0; i < 16; i++) push_beat(exp_beats, 4'(i), 32'h100 + i);
        exp_done++;
        start_op(1'b0, 4'd0, 4'd15);
        @(negedge clk);
        chk("save_first_latency", 64'(out_valid), 64'd0);
        chk("save_busy", 64'(busy), 64'd1);
        chk("save_no_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("save_consecutive", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        chk("save_done_timing", 64'(done), 64'd1);
        wait_idle("save_full_drain");

        // 2: backpressure 1,0,0 repeating
        push_beat(exp_beats, 4'd3, 32'h103);
        push_beat(exp_beats, 4'd4, 32'h104);
        push_beat(exp_beats, 4'd5, 32'h105);
        exp_done++;
        start_op(1'b0, 4'd3, 4'd5);
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 3 == 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle("save_bp_drain");

        // 3: restore at the top of the register file with a gap
        push_beat(exp_wr, 4'd14, 32'hDEAD0001);
        push_beat(exp_wr, 4'd15, 32'hDEAD0002);
        exp_done++;
        start_op(1'b1, 4'd14, 4'd15);
        in_valid = 1'b1; in_data = 32'hDEAD0001;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 32'hDEAD0002;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle("restore_drain");
        chk("restore_r14", 64'(mem[14]), 64'hDEAD0001);
        chk("restore_r15", 64'(mem[15]), 64'hDEAD0002);
        chk("restore_r0_untouched", 64'(mem[0]), 64'h100);
        chk("restore_in_ready_off", 64'(in_ready), 64'd0);

        // 4a: empty range
        exp_done++;
        start_op(1'b0, 4'd7, 4'd6);
        @(negedge clk);
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_no_valid", 64'(out_valid), 64'd0);
        wait_idle("empty_drain");

        // 4b: single register
        push_beat(exp_beats, 4'd9, 32'h109);
        exp_done++;
        start_op(1'b0, 4'd9, 4'd9);
        wait_idle("single_drain");

        // 5a: abort a restore on the fourth write
        for (int i = 0; i < 4; i++) push_beat(exp_wr, 4'(i), 32'hA0 + i);
        start_op(1'b1, 4'd0, 4'd15);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hA0 + i; abort = (i == 3);
            @(posedge clk); #1;
        end
        abort = 1'b0; in_data = 32'hEE;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle("abort_drain");
        chk("abort_r3", 64'(mem[3]), 64'hA3);
        chk("abort_r4", 64'(mem[4]), 64'h104);

        // 5b: reset during a restore with a beat presented
        push_beat(exp_wr, 4'd0, 32'hB0);
        push_beat(exp_wr, 4'd1, 32'hB1);
        start_op(1'b1, 4'd0, 4'd15);
        in_valid = 1'b1; in_data = 32'hB0;
        @(posedge clk); #1 in_data = 32'hB1;
        @(posedge clk); #1 in_data = 32'hB2; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_out_idx", 64'(out_idx), 64'd0);
        chk("mid_rst_rf_we", 64'(rf_we), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        wait_idle("mid_rst_drain");
        chk("mid_rst_r2", 64'(mem[2]), 64'hA2);

        // 6: start while busy, then start in the DONE cycle
        push_beat(exp_beats, 4'd10, 32'h10A);
        push_beat(exp_beats, 4'd11, 32'h10B);
        push_beat(exp_beats, 4'd12, 32'h10C);
        exp_done++;
        out_ready = 1'b0;
        start_op(1'b0, 4'd10, 4'd12);
        start = 1'b1; mode = 1'b1; lo = 4'd0; hi = 4'd15;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int k = 0; k < 50 && done !== 1'b1; k++) @(negedge clk);
        chk("busy_start_done_seen", 64'(done), 64'd1);
        start = 1'b1; mode = 1'b0; lo = 4'd0; hi = 4'd0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_in_done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("start_in_done_valid", 64'(out_valid), 64'd0);
        wait_idle("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
